ranger_patrol_ctrl: RTL and testbench

Per-enemy patrol controller that generates the one-hot movement commands consumed by the ranger position stage (4-bit `inputs`: 1000 up, 0100 down, 0010 left, 0001 right). It divides the system clock into move ticks and walks a back-and-forth patrol leg along one axis. At each end of the leg it dwells, then reverses heading. A collision/wall `blocked` flag fed back from the map logic forces an early reversal. One instance per ranger; its `move` output drives the ranger's `inputs` port directly.

---
 rtl/ranger_patrol_ctrl.sv | 138 +++++++++++++
 tb/tb_ranger_patrol_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ranger_patrol_ctrl.sv
// Per-ranger patrol controller: divides clk into move ticks and walks a back-and-forth
// leg on one axis, dwelling at each end and reversing early when the way is blocked.
module ranger_patrol_ctrl #(
    parameter int unsigned TICK_DIV    = 416667,
    parameter int unsigned LEG_STEPS   = 16,
    parameter int unsigned DWELL_TICKS = 8,
    parameter bit          AXIS        = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       pause,
    input  logic       blocked,
    output logic [3:0] move,
    output logic       heading,
    output logic [1:0] state
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (LEG_STEPS > 1) ? $clog2(LEG_STEPS) : 1;
    localparam int unsigned DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(LEG_STEPS - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_MOVE  = 2'b01,
        ST_DWELL = 2'b10
    } state_t;

    state_t        state_r;
    logic [TW-1:0] tick_cnt_r;
    logic [SW-1:0] step_cnt_r;
    logic [DW-1:0] dwell_cnt_r;
    logic          heading_r;
    logic [3:0]    move_r;
    logic          tick_s;
    logic [3:0]    dir_s;

    // One-hot command for the current heading on the selected axis.
    function automatic logic [3:0] dir_of(input logic axis, input logic hd);
        logic [3:0] d;
        case ({axis, hd})
            2'b00:   d = 4'b0001;
            2'b01:   d = 4'b0010;
            2'b10:   d = 4'b0100;
            2'b11:   d = 4'b1000;
            default: d = 4'b0000;
        endcase
        return d;
    endfunction

    // Tick strobe: end of a divider period while patrolling or dwelling.
    always_comb begin
        tick_s = 1'b0;
        if ((state_r == ST_MOVE) || (state_r == ST_DWELL)) begin
            tick_s = (tick_cnt_r == TICK_LAST);
        end else begin
            tick_s = 1'b0;
        end
    end

    // Direction lookup for the current heading.
    always_comb begin
        dir_s = dir_of(AXIS, heading_r);
    end

    // Patrol state machine; pause freezes everything but still clears the move pulse.
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            state_r     <= ST_IDLE;
            tick_cnt_r  <= '0;
            step_cnt_r  <= '0;
            dwell_cnt_r <= '0;
            heading_r   <= 1'b0;
            move_r      <= 4'b0000;
        end else if (pause) begin
            move_r <= 4'b0000;
        end else begin
            move_r <= 4'b0000;
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_MOVE;
                    tick_cnt_r <= '0;
                end
                ST_MOVE: begin
                    if (tick_s) begin
                        tick_cnt_r <= '0;
                        if (blocked) begin
                            step_cnt_r  <= '0;
                            dwell_cnt_r <= '0;
                            state_r     <= ST_DWELL;
                        end else begin
                            move_r <= dir_s;
                            if (step_cnt_r == STEP_LAST) begin
                                step_cnt_r  <= '0;
                                dwell_cnt_r <= '0;
                                state_r     <= ST_DWELL;
                            end else begin
                                step_cnt_r <= step_cnt_r + SW'(1);
                            end
                        end
                    end else begin
                        tick_cnt_r <= tick_cnt_r + TW'(1);
                    end
                end
                ST_DWELL: begin
                    if (tick_s) begin
                        tick_cnt_r <= '0;
                        if (dwell_cnt_r == DWELL_LAST) begin
                            heading_r   <= ~heading_r;
                            dwell_cnt_r <= '0;
                            state_r     <= ST_MOVE;
                        end else begin
                            dwell_cnt_r <= dwell_cnt_r + DW'(1);
                        end
                    end else begin
                        tick_cnt_r <= tick_cnt_r + TW'(1);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    tick_cnt_r  <= '0;
                    step_cnt_r  <= '0;
                    dwell_cnt_r <= '0;
                    heading_r   <= 1'b0;
                end
            endcase
        end
    end

    assign move    = move_r;
    assign heading = heading_r;
    assign state   = state_r;

endmodule

// File: tb/tb_ranger_patrol_ctrl.sv
// Bench for ranger_patrol_ctrl: directed scenarios plus random traffic checked against a
// tick-plan model (a queue of pending move/dwell/turn actions) for both patrol axes.
module tb_ranger_patrol_ctrl;

    localparam int unsigned TICK_DIV    = 4;
    localparam int unsigned LEG_STEPS   = 3;
    localparam int unsigned DWELL_TICKS = 2;
    localparam int TOK_MOVE  = 0;
    localparam int TOK_DWELL = 1;
    localparam int TOK_TURN  = 2;

    logic       clk = 1'b0;
    logic       rst_n, enable, pause, blocked;
    logic [3:0] move0, move1;
    logic       heading0, heading1;
    logic [1:0] state0, state1;

    ranger_patrol_ctrl #(.TICK_DIV(TICK_DIV), .LEG_STEPS(LEG_STEPS),
                         .DWELL_TICKS(DWELL_TICKS), .AXIS(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pause(pause), .blocked(blocked),
        .move(move0), .heading(heading0), .state(state0));

    ranger_patrol_ctrl #(.TICK_DIV(TICK_DIV), .LEG_STEPS(LEG_STEPS),
                         .DWELL_TICKS(DWELL_TICKS), .AXIS(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pause(pause), .blocked(blocked),
        .move(move1), .heading(heading1), .state(state1));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ncyc   = 0;
    int pulses[$];
    int exp_q[$];

    bit m_run     = 1'b0;
    int m_phase   = 0;
    bit m_heading = 1'b0;
    bit m_pulse   = 1'b0;
    int m_plan[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, ncyc);
        end
    endtask

    task automatic chk_pulses(input string tag, input int exp[$]);
        chk({tag, "_count"}, pulses.size(), exp.size());
        for (int i = 0; i < exp.size() && i < pulses.size(); i++) begin
            chk({tag, "_time"}, pulses[i], exp[i]);
        end
    endtask

    task automatic refill_plan();
        for (int i = 0; i < int'(LEG_STEPS); i++) m_plan.push_back(TOK_MOVE);
        for (int i = 0; i < int'(DWELL_TICKS) - 1; i++) m_plan.push_back(TOK_DWELL);
        m_plan.push_back(TOK_TURN);
    endtask

    task automatic model_edge(input bit r_n, input bit en, input bit p, input bit b);
        int tok;
        m_pulse = 1'b0;
        if (!r_n || !en) begin
            m_run = 1'b0; m_phase = 0; m_heading = 1'b0; m_plan.delete();
        end else if (!p) begin
            if (!m_run) begin
                m_run = 1'b1; m_phase = 0; m_plan.delete(); refill_plan();
            end else begin
                m_phase++;
                if (m_phase == int'(TICK_DIV)) begin
                    m_phase = 0;
                    tok = m_plan.pop_front();
                    if (tok == TOK_MOVE) begin
                        if (b) begin
                            while (m_plan.size() > 0 && m_plan[0] == TOK_MOVE) void'(m_plan.pop_front());
                        end else begin
                            m_pulse = 1'b1;
                        end
                    end else if (tok == TOK_TURN) begin
                        m_heading = ~m_heading;
                    end
                    if (m_plan.size() == 0) refill_plan();
                end
            end
        end
    endtask

    function automatic logic [3:0] exp_move(input bit axis);
        if (!m_pulse) return 4'b0000;
        if (!axis) return m_heading ? 4'b0010 : 4'b0001;
        return m_heading ? 4'b1000 : 4'b0100;
    endfunction

    function automatic logic [1:0] exp_state();
        if (!m_run) return 2'b00;
        return (m_plan[0] == TOK_MOVE) ? 2'b01 : 2'b10;
    endfunction

    task automatic drive_cycle(input bit r_n, input bit en, input bit p, input bit b);
        rst_n = r_n; enable = en; pause = p; blocked = b;
        @(posedge clk);
        model_edge(r_n, en, p, b);
        #1;
        ncyc++;
        chk("move_ax0", move0, exp_move(1'b0));
        chk("move_ax1", move1, exp_move(1'b1));
        chk("state_ax0", state0, exp_state());
        chk("state_ax1", state1, exp_state());
        chk("heading_ax0", heading0, m_heading);
        chk("heading_ax1", heading1, m_heading);
        chk("onehot_ax0", ($countones(move0) <= 1), 1);
        chk("onehot_ax1", ($countones(move1) <= 1), 1);
        if (move0 != 4'b0000) pulses.push_back(ncyc);
    endtask

    task automatic start_scenario();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        ncyc = 0;
        pulses.delete();
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; pause = 1'b0; blocked = 1'b0;

        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Full patrol: forward leg, dwell, back leg, dwell, forward again.
        start_scenario();
        for (int i = 0; i < 46; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        exp_q = '{5, 9, 13, 25, 29, 33, 45};
        chk_pulses("full_patrol", exp_q);

        // Blocked on the second forward tick; an off-tick blocked is ignored.
        start_scenario();
        for (int i = 1; i <= 30; i++) drive_cycle(1'b1, 1'b1, 1'b0, (i == 7) || (i == 9));
        exp_q = '{5, 21, 25, 29};
        chk_pulses("blocked", exp_q);

        // Seven-cycle pause between the first and second pulses.
        start_scenario();
        for (int i = 1; i <= 21; i++) drive_cycle(1'b1, 1'b1, (i >= 6) && (i <= 12), 1'b0);
        exp_q = '{5, 16, 20};
        chk_pulses("pause", exp_q);

        // Enable drop mid-dwell, then restart.
        start_scenario();
        for (int i = 0; i < 15; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("dwell_before_drop", state0, 2'b10);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("drop_state", state0, 2'b00);
        chk("drop_move", move0, 4'b0000);
        ncyc = 0; pulses.delete();
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        exp_q = '{5};
        chk_pulses("reenable", exp_q);

        // Reset mid-back-leg, then restart.
        start_scenario();
        for (int i = 0; i < 26; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("heading_back", heading0, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst_state", state0, 2'b00);
        chk("rst_heading", heading0, 1'b0);
        ncyc = 0; pulses.delete();
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        exp_q = '{5};
        chk_pulses("after_reset", exp_q);

        // Random traffic against the plan model.
        for (int i = 0; i < 1500; i++) begin
            drive_cycle($urandom_range(99) != 0, $urandom_range(199) != 0,
                        $urandom_range(9) == 0, $urandom_range(99) < 15);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
